// File: rtl/axil_cmd_master.sv
// -----------------------------------------------------------------------------
// axil_cmd_master
//
// Command-driven AXI4-Lite initiator used by sequencers and debug bridges to
// reach the generated register blocks.  One read or write command is taken
// per valid/ready handshake.  The full AXI-Lite transaction is run, and the
// data and response are returned on the rsp_* channel.  Only one transaction
// is ever outstanding.
//
// Optional build macro: AXIL_CMD_MASTER_TIMEOUT_EN
//   When defined, a watchdog aborts any transaction that stays in an address,
//   data or wait state for TIMEOUT_CYCLES cycles.  The abort returns
//   resp=2'b10 with o_rsp_timeout=1.  When undefined, there is no counter,
//   o_rsp_timeout is tied low, and the master waits indefinitely.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready   command handshake (ready only while idle)
//   i_cmd_we                  1 = write, 0 = read
//   i_cmd_addr/wdata/wstrb    command payload, registered on acceptance
//   o_rsp_valid/i_rsp_ready   response handshake (valid held until ready)
//   o_rsp_rdata               read data (0 for writes and timeouts)
//   o_rsp_resp                BRESP/RRESP of the transaction
//   o_rsp_timeout             transaction aborted by the watchdog
//   o_busy                    FSM not idle
//   o_m_axil_* / i_m_axil_*   AXI4-Lite master channels AW, W, B, AR, R
// -----------------------------------------------------------------------------
module axil_cmd_master #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int STRB_W         = DATA_W / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    input  logic [STRB_W-1:0] i_cmd_wstrb,

    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic [1:0]        o_rsp_resp,
    output logic              o_rsp_timeout,
    output logic              o_busy,

    output logic [ADDR_W-1:0] o_m_axil_awaddr,
    output logic [2:0]        o_m_axil_awprot,
    output logic              o_m_axil_awvalid,
    input  logic              i_m_axil_awready,

    output logic [DATA_W-1:0] o_m_axil_wdata,
    output logic [STRB_W-1:0] o_m_axil_wstrb,
    output logic              o_m_axil_wvalid,
    input  logic              i_m_axil_wready,

    input  logic [1:0]        i_m_axil_bresp,
    input  logic              i_m_axil_bvalid,
    output logic              o_m_axil_bready,

    output logic [ADDR_W-1:0] o_m_axil_araddr,
    output logic [2:0]        o_m_axil_arprot,
    output logic              o_m_axil_arvalid,
    input  logic              i_m_axil_arready,

    input  logic [DATA_W-1:0] i_m_axil_rdata,
    input  logic [1:0]        i_m_axil_rresp,
    input  logic              i_m_axil_rvalid,
    output logic              o_m_axil_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_RD_ADDR,
        S_WAIT_B,
        S_WAIT_R,
        S_RSP
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_aw_done;
    logic              r_w_done;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [1:0]        r_rsp_resp;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_accept;
    logic              w_finish;
    logic [DATA_W-1:0] w_fin_rdata;
    logic [1:0]        w_fin_resp;

    // -------------------------------------------------------------------------
    // Channel outputs decode directly from state, so every valid/ready drops
    // in the cycle after the state machine leaves the owning state (reset,
    // completion or watchdog abort alike).
    // -------------------------------------------------------------------------
    assign o_cmd_ready      = (r_state == S_IDLE);
    assign o_busy           = (r_state != S_IDLE);
    assign o_rsp_valid      = (r_state == S_RSP);
    assign o_rsp_rdata      = r_rsp_rdata;
    assign o_rsp_resp       = r_rsp_resp;

    assign o_m_axil_awaddr  = r_addr;
    assign o_m_axil_awprot  = 3'b000;
    assign o_m_axil_awvalid = (r_state == S_WR_ADDR_DATA) && !r_aw_done;
    assign o_m_axil_wdata   = r_wdata;
    assign o_m_axil_wstrb   = r_wstrb;
    assign o_m_axil_wvalid  = (r_state == S_WR_ADDR_DATA) && !r_w_done;
    assign o_m_axil_bready  = (r_state == S_WAIT_B);
    assign o_m_axil_araddr  = r_addr;
    assign o_m_axil_arprot  = 3'b000;
    assign o_m_axil_arvalid = (r_state == S_RD_ADDR);
    assign o_m_axil_rready  = (r_state == S_WAIT_R);

    assign w_aw_hs = o_m_axil_awvalid && i_m_axil_awready;
    assign w_w_hs  = o_m_axil_wvalid  && i_m_axil_wready;
    assign w_ar_hs = o_m_axil_arvalid && i_m_axil_arready;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_counting;
    logic             w_timeout_hit;
    logic             w_fin_timeout;

    // The watchdog only runs while waiting on the interconnect; it holds at
    // zero in IDLE and RSP so each transaction starts from a clean count.
    assign w_counting    = (r_state == S_WR_ADDR_DATA) || (r_state == S_RD_ADDR) ||
                           (r_state == S_WAIT_B)       || (r_state == S_WAIT_R);
    assign w_timeout_hit = w_counting && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_rsp_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (rst || !w_counting) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_finish) begin
            r_timeout <= w_fin_timeout;
        end
    end
`else
    assign o_rsp_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_fin_rdata  = '0;
        w_fin_resp   = 2'b00;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        w_fin_timeout = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = i_cmd_we ? S_WR_ADDR_DATA : S_RD_ADDR;
                end
            end
            S_WR_ADDR_DATA: begin
                // AW and W finish independently; move on once both are done,
                // counting a handshake happening in this very cycle.
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next_state = S_WAIT_B;
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_next_state = S_WAIT_R;
                end
            end
            S_WAIT_B: begin
                if (i_m_axil_bvalid) begin
                    w_next_state = S_RSP;
                    w_finish     = 1'b1;
                    w_fin_resp   = i_m_axil_bresp;
                end
            end
            S_WAIT_R: begin
                if (i_m_axil_rvalid) begin
                    w_next_state = S_RSP;
                    w_finish     = 1'b1;
                    w_fin_rdata  = i_m_axil_rdata;
                    w_fin_resp   = i_m_axil_rresp;
                end
            end
            S_RSP: begin
                if (i_rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        // A B/R response landing on the expiry cycle is kept; otherwise the
        // watchdog abandons the transaction.
        if (w_timeout_hit && !w_finish) begin
            w_next_state  = S_RSP;
            w_finish      = 1'b1;
            w_fin_rdata   = '0;
            w_fin_resp    = 2'b10;
            w_fin_timeout = 1'b1;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // NOTE: payload registers have no reset; they are only observed while a valid qualifies them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= i_cmd_addr;
            r_wdata <= i_cmd_wdata;
            r_wstrb <= i_cmd_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else if (w_finish) begin
            r_rsp_rdata <= w_fin_rdata;
            r_rsp_resp  <= w_fin_resp;
        end
    end

endmodule
